// File: rtl/corr_pkg.sv
// Shared types and register offsets for the correlator readout scheduler.
package corr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD_CNT,
    RD_LOW,
    RD_HIGH,
    RD_STAT,
    PUSH
  } corr_rd_state_t;

  localparam logic [31:0] CORR_OFS_CNT  = 32'h0;
  localparam logic [31:0] CORR_OFS_LOW  = 32'h4;
  localparam logic [31:0] CORR_OFS_HIGH = 32'h8;
  localparam logic [31:0] CORR_OFS_STAT = 32'hC;

  typedef struct packed {
    logic [3:0]  chan;
    logic [31:0] cnt;
    logic [31:0] low;
    logic [31:0] high;
    logic        stale;
  } corr_result_t;

endpackage

// File: rtl/corr_readout_sched_rr_pick.sv
// Combinational round-robin picker: first set request strictly above ptr, wrapping.
module rr_pick #(
  parameter int N = 16
) (
  input  logic [N-1:0] req,
  input  logic [3:0]   ptr,
  output logic [N-1:0] gnt,
  output logic [3:0]   idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (((int'(ptr) + k) % N) == i)) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
          idx    = 4'(i);
        end
      end
    end
  end

endmodule

// File: rtl/corr_readout_sched.sv
// Round-robin drain of correlator results over the shared register bus; record 5 edges after pick with
// grant held, holds in PUSH while res_ready=0. Optional res_time via CORR_READOUT_TIMESTAMP_EN.
module corr_readout_sched
  import corr_pkg::*;
#(
  parameter int          NCH       = 16,
  parameter logic [31:0] BASE_ADDR = 32'hFE0006F0,
  parameter logic [31:0] CH_STRIDE = 32'h00001000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] seen,
  output logic           bus_req,
  input  logic           bus_gnt,
  output logic [31:0]    addr,
  output logic           read,
  input  logic [31:0]    Rdata,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [3:0]     res_chan,
  output logic [31:0]    res_cnt,
  output logic [31:0]    res_low,
  output logic [31:0]    res_high,
  output logic           res_stale
`ifdef CORR_READOUT_TIMESTAMP_EN
  ,
  output logic [31:0]    res_time
`endif
);

  corr_rd_state_t state, state_nxt, rd_nxt;
  corr_result_t   rec;
  logic [3:0]     rr_ptr;
  logic           just_pushed;
  logic [NCH-1:0] masked;
  logic [NCH-1:0] pick_gnt;
  logic [3:0]     pick_idx;
  logic           pick_any;
  logic [31:0]    ofs;

  // seen clears one edge late after the Status read, so hide the channel just served
  always_comb begin
    masked = seen;
    if (just_pushed) masked[rec.chan] = 1'b0;
  end

  rr_pick #(.N(NCH)) u_pick (
    .req (masked),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign pick_any = |pick_gnt;

  always_comb begin
    ofs    = CORR_OFS_CNT;
    rd_nxt = RD_LOW;
    case (state)
      RD_LOW:  begin ofs = CORR_OFS_LOW;  rd_nxt = RD_HIGH; end
      RD_HIGH: begin ofs = CORR_OFS_HIGH; rd_nxt = RD_STAT; end
      RD_STAT: begin ofs = CORR_OFS_STAT; rd_nxt = PUSH;    end
      default: begin ofs = CORR_OFS_CNT;  rd_nxt = RD_LOW;  end
    endcase
  end

  always_comb begin
    state_nxt = state;
    bus_req   = 1'b0;
    read      = 1'b0;
    addr      = '0;
    case (state)
      IDLE: if (pick_any) state_nxt = REQ;
      REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) state_nxt = RD_CNT;
      end
      RD_CNT, RD_LOW, RD_HIGH, RD_STAT: begin
        bus_req = 1'b1;
        read    = bus_gnt;
        if (bus_gnt) begin
          addr      = BASE_ADDR + 32'(rec.chan) * CH_STRIDE + ofs;
          state_nxt = rd_nxt;
        end
      end
      PUSH: if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rec         <= '0;
      rr_ptr      <= 4'(NCH - 1);
      just_pushed <= 1'b0;
    end else begin
      state       <= state_nxt;
      just_pushed <= (state == PUSH) && res_ready;
      if (state == IDLE && pick_any) rec.chan <= pick_idx;
      if (bus_gnt) begin
        case (state)
          RD_CNT:  rec.cnt  <= Rdata;
          RD_LOW:  rec.low  <= Rdata;
          RD_HIGH: rec.high <= Rdata;
          RD_STAT: begin
            rec.stale <= ~Rdata[0];
            rr_ptr    <= rec.chan;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CORR_READOUT_TIMESTAMP_EN
  logic [31:0] cyc;
  logic [31:0] rec_time;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc      <= '0;
      rec_time <= '0;
    end else begin
      cyc <= cyc + 32'd1;
      if (state == IDLE && pick_any) rec_time <= cyc;
    end
  end

  assign res_time = rec_time;
`endif

  assign res_valid = (state == PUSH);
  assign res_chan  = rec.chan;
  assign res_cnt   = rec.cnt;
  assign res_low   = rec.low;
  assign res_high  = rec.high;
  assign res_stale = rec.stale;

endmodule

// File: tb/tb_corr_readout_sched.sv
// Directed bench for corr_readout_sched with a register-file model that clears seen after Status reads.
module tb_corr_readout_sched;

  localparam logic [31:0] BASE = 32'hFE0006F0;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] seen;
  logic        bus_req, bus_gnt, read, res_valid, res_ready, res_stale;
  logic [31:0] addr, Rdata, res_cnt, res_low, res_high;
  logic [3:0]  res_chan;
`ifdef CORR_READOUT_TIMESTAMP_EN
  logic [31:0] res_time;
`endif

  logic [31:0] m_cnt [16];
  logic [31:0] m_low [16];
  logic [31:0] m_high[16];
  logic [31:0] m_stat[16];
  logic [15:0] pend_clr;
  logic [31:0] off;
  logic [3:0]  rch;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  corr_readout_sched dut (
    .clk       (clk),
    .rst       (rst),
    .seen      (seen),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .addr      (addr),
    .read      (read),
    .Rdata     (Rdata),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_chan  (res_chan),
    .res_cnt   (res_cnt),
    .res_low   (res_low),
    .res_high  (res_high),
    .res_stale (res_stale)
`ifdef CORR_READOUT_TIMESTAMP_EN
    ,
    .res_time  (res_time)
`endif
  );

  always_comb begin
    off = addr - BASE;
    rch = off[15:12];
    case (off[3:0])
      4'h0:    Rdata = m_cnt[rch];
      4'h4:    Rdata = m_low[rch];
      4'h8:    Rdata = m_high[rch];
      default: Rdata = m_stat[rch];
    endcase
  end

  typedef struct {
    logic [15:0] seen;
    logic [31:0] cnt, low, high, stat;
    int          ch;
    logic [31:0] a0;
    logic        stale;
  } vec_t;

  vec_t vt[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Status read observed in this cycle clears seen at the edge after next
  task automatic step();
    logic [15:0] cl, nw;
    cl = pend_clr;
    nw = '0;
    if (read && off[3:0] == 4'hC) nw[rch] = 1'b1;
    pend_clr = nw;
    @(posedge clk);
    #1;
    seen = seen & ~cl;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst bus_req", 32'(bus_req), 32'd0);
    chk("rst read", 32'(read), 32'd0);
    chk("rst addr", addr, 32'd0);
    chk("rst res_valid", 32'(res_valid), 32'd0);
    pend_clr = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (!bus_req && n < 40) begin
      step();
      n++;
    end
    chk({nm, " req"}, 32'(bus_req), 32'd1);
  endtask

  task automatic expect_service(input string nm, input int ch, input logic [31:0] a0,
                                input logic [31:0] cnt, input logic [31:0] low,
                                input logic [31:0] high, input logic stale);
    wait_req(nm);
    chk({nm, " req read"}, 32'(read), 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      chk({nm, " read"}, 32'(read), 32'd1);
      chk({nm, " addr"}, addr, a0 + 32'(4 * k));
      chk({nm, " early valid"}, 32'(res_valid), 32'd0);
      step();
    end
    chk({nm, " valid"}, 32'(res_valid), 32'd1);
    chk({nm, " chan"}, 32'(res_chan), 32'(ch));
    chk({nm, " cnt"}, res_cnt, cnt);
    chk({nm, " low"}, res_low, low);
    chk({nm, " high"}, res_high, high);
    chk({nm, " stale"}, 32'(res_stale), 32'(stale));
    chk({nm, " push req"}, 32'(bus_req), 32'd0);
    step();
  endtask

  initial begin
    int nv;
    for (int i = 0; i < 16; i++) begin
      m_cnt[i]  = 32'h100 + 32'(i);
      m_low[i]  = 32'h200 + 32'(i);
      m_high[i] = 32'h300 + 32'(i);
      m_stat[i] = 32'h1;
    end
    vt[0] = '{16'h0008, 32'h64, 32'h1234, 32'h0, 32'h1, 3, 32'hFE0036F0, 1'b0};
    vt[1] = '{16'h0020, 32'hA5A5, 32'hFFFFFFFF, 32'h1, 32'h0, 5, 32'hFE0056F0, 1'b1};
    vt[2] = '{16'h8000, 32'h1, 32'h2, 32'hDEADBEEF, 32'h3, 15, 32'hFE00F6F0, 1'b0};
    vt[3] = '{16'h0001, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32'hFFFFFFFE, 0, 32'hFE0006F0, 1'b1};

    seen = '0; bus_gnt = 1'b1; res_ready = 1'b1; pend_clr = '0; rst = 1'b1;
    @(negedge clk);
    do_reset();
    chk("rst chan", 32'(res_chan), 32'd0);
    chk("rst cnt", res_cnt, 32'd0);
    chk("rst stale", 32'(res_stale), 32'd0);

    // single events, including a stale Status
    for (int v = 0; v < 4; v++) begin
      m_cnt[vt[v].ch]  = vt[v].cnt;
      m_low[vt[v].ch]  = vt[v].low;
      m_high[vt[v].ch] = vt[v].high;
      m_stat[vt[v].ch] = vt[v].stat;
      seen = vt[v].seen;
      expect_service($sformatf("vec%0d", v), vt[v].ch, vt[v].a0, vt[v].cnt, vt[v].low,
                     vt[v].high, vt[v].stale);
      step();
      chk($sformatf("vec%0d seen cleared", v), 32'(seen), 32'd0);
      chk($sformatf("vec%0d idle", v), 32'(bus_req), 32'd0);
    end

    // round robin: ch0, ch15, then the re-raised ch0
    do_reset();
    m_stat[0] = 32'h1; m_stat[15] = 32'h1;
    seen = 16'h8001;
    expect_service("rr0", 0, 32'hFE0006F0, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    seen[0] = 1'b1;
    expect_service("rr15", 15, 32'hFE00F6F0, 32'h1, 32'h2, 32'hDEADBEEF, 1'b0);
    expect_service("rr0b", 0, 32'hFE0006F0, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);

    // grant stall during RD_LOW
    m_low[2] = 32'hCAFEF00D;
    seen = 16'h0004;
    wait_req("stall");
    step();
    chk("stall cnt addr", addr, 32'hFE0026F0);
    step();
    bus_gnt = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("stall read", 32'(read), 32'd0);
      chk("stall addr", addr, 32'd0);
      chk("stall req", 32'(bus_req), 32'd1);
      step();
    end
    bus_gnt = 1'b1;
    #1;
    chk("stall low read", 32'(read), 32'd1);
    chk("stall low addr", addr, 32'hFE0026F4);
    step();
    chk("stall high addr", addr, 32'hFE0026F8);
    step();
    chk("stall stat addr", addr, 32'hFE0026FC);
    step();
    chk("stall valid", 32'(res_valid), 32'd1);
    chk("stall low", res_low, 32'hCAFEF00D);
    step();

    // backpressure with ch1 pending
    do_reset();
    seen = 16'h0003;
    res_ready = 1'b0;
    wait_req("bp");
    repeat (5) step();
    for (int c = 0; c < 10; c++) begin
      chk("bp valid", 32'(res_valid), 32'd1);
      chk("bp chan", 32'(res_chan), 32'd0);
      chk("bp cnt", res_cnt, 32'hFFFFFFFF);
      chk("bp high", res_high, 32'h80000000);
      chk("bp req", 32'(bus_req), 32'd0);
      step();
    end
    res_ready = 1'b1;
    step();
    expect_service("bp1", 1, 32'hFE0016F0, 32'h101, 32'h201, 32'h301, 1'b0);

    // reset in RD_HIGH, then exactly one clean record
    seen = 16'h0010;
    wait_req("mid");
    repeat (3) step();
    chk("mid high addr", addr, 32'hFE0046F8);
    do_reset();
    chk("mid seen kept", 32'(seen), 32'h10);
    expect_service("mid4", 4, 32'hFE0046F0, 32'h104, 32'h204, 32'h304, 1'b0);
    nv = 0;
    for (int c = 0; c < 15; c++) begin
      if (res_valid) nv++;
      step();
    end
    chk("mid extra records", 32'(nv), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
